// File: rtl/eth_tx_arb_pkg.sv
// rtl/eth_tx_arb_pkg.sv - shared types, defaults and round-robin helper for the MII transmit arbiter
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        IFG   = 2'd3
    } arb_state_t;

    localparam int DEF_IFG_NIBBLES   = 24;
    localparam int DEF_START_TIMEOUT = 16;
    localparam int DEF_MAX_NIBBLES   = 3052;

    // Prefer the source that did not win last time; otherwise keep the requester.
    // The result is only meaningful when at least one request bit is set.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req[~last]) begin
            return ~last;
        end
        return last;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin, frame-atomic two-source arbiter for the MII transmit nibble path
//
// Ports:
//   eth_mii_clk  MII transmit clock, sole clock
//   sys_rst_n    synchronous active-low reset
//   src_req      per-source level frame request, held until granted
//   src_dv       per-source nibble valid (only the granted bit is used)
//   src_data     per-source nibble, [3:0] source 0, [7:4] source 1
//   src_gnt      registered one-hot grant
//   tx_dv        muxed MII valid toward mii_to_rmii
//   tx_data      muxed MII nibble toward mii_to_rmii (zero while tx_dv is low)
//   busy         high whenever the arbiter is not idle
//   err_timeout  one-cycle pulse: granted source never started its frame
//   err_overlen  one-cycle pulse: frame cut at MAX_NIBBLES
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int IFG_NIBBLES   = DEF_IFG_NIBBLES,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int MAX_NIBBLES   = DEF_MAX_NIBBLES
) (
    input  logic       eth_mii_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] src_req,
    input  logic [1:0] src_dv,
    input  logic [7:0] src_data,
    output logic [1:0] src_gnt,
    output logic       tx_dv,
    output logic [3:0] tx_data,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_overlen
);

    localparam int CNT_W = $clog2(MAX_NIBBLES + 1);
    localparam int TMR_W = $clog2(((IFG_NIBBLES > START_TIMEOUT) ? IFG_NIBBLES : START_TIMEOUT) + 1);

    localparam logic [CNT_W-1:0] NIB_LAST = CNT_W'(MAX_NIBBLES);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(IFG_NIBBLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(START_TIMEOUT - 1);

    arb_state_t       state;
    logic             last_winner;
    logic [CNT_W-1:0] nibble_cnt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] gap_cnt;

    logic             winner;
    logic             sel_dv;
    logic             sel_req;
    logic [3:0]       sel_data;

    // While a grant is outstanding last_winner is the granted source, so it
    // doubles as the mux select for the whole frame.
    assign winner   = rr_pick(src_req, last_winner);
    assign sel_dv   = src_dv[last_winner];
    assign sel_req  = src_req[last_winner];
    assign sel_data = last_winner ? src_data[7:4] : src_data[3:0];
    assign busy     = (state != IDLE);

    always_ff @(posedge eth_mii_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            src_gnt     <= 2'b00;
            tx_dv       <= 1'b0;
            tx_data     <= 4'h0;
            err_timeout <= 1'b0;
            err_overlen <= 1'b0;
            nibble_cnt  <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
        end else begin
            err_timeout <= 1'b0;
            err_overlen <= 1'b0;
            case (state)
                IDLE: begin
                    if (|src_req) begin
                        src_gnt     <= winner ? 2'b10 : 2'b01;
                        last_winner <= winner;
                        timer       <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // dv beats both the request drop and the timeout.
                    if (sel_dv) begin
                        tx_dv      <= 1'b1;
                        tx_data    <= sel_data;
                        nibble_cnt <= CNT_W'(1);
                        state      <= SEND;
                    end else if (!sel_req) begin
                        src_gnt <= 2'b00;
                        state   <= IDLE;
                    end else if (timer == TMO_LAST) begin
                        src_gnt     <= 2'b00;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SEND: begin
                    if (!sel_dv || nibble_cnt == NIB_LAST) begin
                        // First dv-low ends the frame; dv still high at the
                        // limit means the rest of the frame is discarded.
                        src_gnt     <= 2'b00;
                        tx_dv       <= 1'b0;
                        tx_data     <= 4'h0;
                        gap_cnt     <= '0;
                        err_overlen <= sel_dv;
                        state       <= IFG;
                    end else begin
                        tx_dv      <= 1'b1;
                        tx_data    <= sel_data;
                        nibble_cnt <= nibble_cnt + 1'b1;
                    end
                end
                IFG: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - scoreboard bench for eth_tx_arbiter with randomized frame sources
module tb_eth_tx_arbiter;
    import eth_tx_arb_pkg::*;

    localparam int IFG  = 24;
    localparam int TMO  = 16;
    localparam int MAXN = 3052;

    typedef struct {
        int len;
        int base;
        int step;
        int delay;
        int mode;      // 0 normal frame, 1 never raise dv, 2 drop request while granted
        bit lat;       // check request-to-grant latency
        bit abrt;      // frame is expected to be cut by a reset
    } frame_t;

    typedef struct {
        int src;
        int len;
        int base;
        int step;
        bit trunc;
        bit abrt;
    } exp_t;

    logic       clk = 1'b0;
    logic       sys_rst_n;
    logic       req0, req1, dv0, dv1;
    logic [3:0] d0, d1;
    logic [1:0] src_req, src_dv, src_gnt;
    logic [7:0] src_data;
    logic       tx_dv, busy, err_timeout, err_overlen;
    logic [3:0] tx_data;

    assign src_req  = {req1, req0};
    assign src_dv   = {dv1, dv0};
    assign src_data = {d1, d0};

    always #5 clk = ~clk;

    eth_tx_arbiter #(
        .IFG_NIBBLES  (IFG),
        .START_TIMEOUT(TMO),
        .MAX_NIBBLES  (MAXN)
    ) dut (
        .eth_mii_clk(clk),
        .sys_rst_n  (sys_rst_n),
        .src_req    (src_req),
        .src_dv     (src_dv),
        .src_data   (src_data),
        .src_gnt    (src_gnt),
        .tx_dv      (tx_dv),
        .tx_data    (tx_data),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_overlen(err_overlen)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input int act, input int want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic logic [3:0] nib(input int base, input int step, input int i);
        return 4'(base + i * step);
    endfunction

    frame_t fq0[$], fq1[$], pq0[$], pq1[$];
    exp_t   exp_q[$];
    int     st_q0[$], st_q1[$];
    bit     abort_req[2];
    bit     noise[2];
    bit     drv_busy[2];
    int     model_last;
    int     n_tmo = 0, n_ovl = 0, exp_tmo = 0, exp_ovl = 0;

    task automatic set_pins(input int s, input logic r, input logic v, input logic [3:0] d);
        if (s == 0) begin req0 = r; dv0 = v; d0 = d; end
        else        begin req1 = r; dv1 = v; d1 = d; end
    endtask

    // Source model: requests each queued frame, waits for its grant, then plays it out.
    task automatic drive_src(input int s);
        frame_t f;
        int     r_cyc, g_cyc;
        bit     got;
        forever begin
            @(posedge clk); #1;
            if ((s == 0 && fq0.size() == 0) || (s == 1 && fq1.size() == 0)) begin
                drv_busy[s] = 1'b0;
                if (noise[s]) set_pins(s, 1'b0, 1'($urandom), 4'($urandom));
                else          set_pins(s, 1'b0, 1'b0, 4'h0);
                continue;
            end
            drv_busy[s] = 1'b1;
            if (s == 0) f = fq0.pop_front();
            else        f = fq1.pop_front();
            set_pins(s, 1'b1, 1'b0, 4'h0);
            r_cyc = cyc;
            got = 1'b0;
            for (int t = 0; t < 2000; t++) begin
                @(posedge clk); #1;
                if (src_gnt[s]) begin got = 1'b1; break; end
            end
            if (!got) begin
                check(1'b0, "grant_wait", 0, 1);
                set_pins(s, 1'b0, 1'b0, 4'h0);
                continue;
            end
            g_cyc = cyc;
            if (f.lat) check(g_cyc - r_cyc == 1, "grant_latency", g_cyc - r_cyc, 1);
            if (f.mode == 1) begin
                got = 1'b0;
                for (int t = 0; t < 40; t++) begin
                    @(posedge clk); #1;
                    if (!src_gnt[s]) begin got = 1'b1; break; end
                end
                check(got && (cyc - g_cyc == TMO), "timeout_cycle", cyc - g_cyc, TMO);
                check(err_timeout == 1'b1, "timeout_pulse", int'(err_timeout), 1);
                set_pins(s, 1'b0, 1'b0, 4'h0);
            end else if (f.mode == 2) begin
                repeat (3) begin @(posedge clk); #1; end
                set_pins(s, 1'b0, 1'b0, 4'h0);
                @(posedge clk); #1;
                check(src_gnt == 2'b00, "drop_gnt", int'(src_gnt), 0);
                check(err_timeout == 1'b0, "drop_no_error", int'(err_timeout), 0);
                check(busy == 1'b0, "drop_idle", int'(busy), 0);
            end else begin
                repeat (f.delay) begin @(posedge clk); #1; end
                for (int i = 0; i < f.len; i++) begin
                    set_pins(s, 1'b0, 1'b1, nib(f.base, f.step, i));
                    if (i == 0) begin
                        if (s == 0) st_q0.push_back(cyc);
                        else        st_q1.push_back(cyc);
                    end
                    @(posedge clk); #1;
                    if (abort_req[s]) begin abort_req[s] = 1'b0; break; end
                end
                set_pins(s, 1'b0, 1'b0, 4'h0);
            end
        end
    endtask

    // Monitor: frames on tx_* are matched against the expected queue.
    bit   mon_en = 1'b0;
    bit   in_run = 1'b0, have_prev = 1'b0;
    int   run_len, run_start, idle_cnt, data_err, last_fall, st;
    exp_t cur;

    always @(negedge clk) begin
        if (mon_en) begin
            check(!(src_gnt[0] && src_gnt[1]), "gnt_onehot", int'(src_gnt), 1);
            check(!(err_timeout && err_overlen), "err_exclusive", int'({err_timeout, err_overlen}), 0);
            if (!tx_dv) check(tx_data == 4'h0, "idle_data", int'(tx_data), 0);
            if (err_timeout) n_tmo++;
            if (err_overlen) n_ovl++;
            if (!sys_rst_n) begin
                if (in_run) check(cur.abrt, "reset_cut_expected", int'(cur.abrt), 1);
                in_run    = 1'b0;
                have_prev = 1'b0;
            end else if (tx_dv) begin
                if (!in_run) begin
                    in_run    = 1'b1;
                    run_start = cyc;
                    run_len   = 0;
                    data_err  = 0;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_frame", 1, 0);
                        cur = '{src: -1, len: -1, base: 0, step: 0, trunc: 1'b0, abrt: 1'b0};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    if (have_prev) check(idle_cnt >= IFG, "ifg_gap", idle_cnt, IFG);
                    if (cur.src >= 0) begin
                        check(src_gnt == 2'(1 << cur.src), "grant_src", int'(src_gnt), 1 << cur.src);
                        if (cur.src == 0 && st_q0.size() > 0)      st = st_q0.pop_front();
                        else if (cur.src == 1 && st_q1.size() > 0) st = st_q1.pop_front();
                        else                                       st = -100;
                        check(run_start == st + 1, "tx_lag", run_start - st, 1);
                    end
                end
                if (cur.src >= 0 && tx_data != nib(cur.base, cur.step, run_len)) data_err++;
                run_len++;
            end else begin
                if (in_run) begin
                    in_run = 1'b0;
                    check(!cur.abrt, "frame_not_reset_cut", int'(cur.abrt), 0);
                    check(run_len == cur.len, "frame_len", run_len, cur.len);
                    check(data_err == 0, "frame_data", data_err, 0);
                    check(err_overlen == cur.trunc, "overlen_flag", int'(err_overlen), int'(cur.trunc));
                    have_prev = 1'b1;
                    idle_cnt  = 1;
                    last_fall = cyc;
                end else begin
                    idle_cnt++;
                end
            end
        end
    end

    function automatic frame_t mk(input int len, input int delay, input int mode, input bit lat, input bit abrt);
        frame_t f;
        f.len   = len;
        f.base  = int'($urandom_range(0, 15));
        f.step  = int'($urandom_range(1, 15));
        f.delay = delay;
        f.mode  = mode;
        f.lat   = lat;
        f.abrt  = abrt;
        return f;
    endfunction

    // Reference model: with both sources pending the one that did not win last
    // is served; otherwise whichever is pending. Frames longer than MAXN are cut.
    task automatic issue();
        frame_t f;
        exp_t   e;
        int     i0, i1, pick;
        @(negedge clk);
        i0 = 0;
        i1 = 0;
        while (i0 < pq0.size() || i1 < pq1.size()) begin
            if (i0 < pq0.size() && i1 < pq1.size()) pick = 1 - model_last;
            else                                    pick = (i0 < pq0.size()) ? 0 : 1;
            if (pick == 0) begin f = pq0[i0]; i0++; end
            else           begin f = pq1[i1]; i1++; end
            if (f.mode == 0) begin
                e.src   = pick;
                e.len   = (f.len > MAXN) ? MAXN : f.len;
                e.base  = f.base;
                e.step  = f.step;
                e.trunc = (f.len > MAXN);
                e.abrt  = f.abrt;
                exp_q.push_back(e);
                if (e.trunc) exp_ovl++;
            end else if (f.mode == 1) begin
                exp_tmo++;
            end
            model_last = pick;
        end
        foreach (pq0[k]) fq0.push_back(pq0[k]);
        foreach (pq1[k]) fq1.push_back(pq1[k]);
        pq0.delete();
        pq1.delete();
    endtask

    task automatic drain(output int t_done);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !in_run && fq0.size() == 0 && fq1.size() == 0 &&
                !drv_busy[0] && !drv_busy[1] && !abort_req[0] && !abort_req[1] && busy == 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check(1'b0, "drain_timeout", exp_q.size(), 0);
        t_done = cyc;
    endtask

    initial begin
        frame_t f;
        int     t_done, n0, n1, cnt;

        sys_rst_n = 1'b0;
        set_pins(0, 1'b0, 1'b0, 4'h0);
        set_pins(1, 1'b0, 1'b0, 4'h0);
        model_last = 1;
        fork
            drive_src(0);
            drive_src(1);
        join_none

        repeat (3) @(posedge clk);
        #1;
        check(src_gnt == 2'b00, "reset_gnt", int'(src_gnt), 0);
        check(tx_dv == 1'b0, "reset_tx_dv", int'(tx_dv), 0);
        check(tx_data == 4'h0, "reset_tx_data", int'(tx_data), 0);
        check(busy == 1'b0, "reset_busy", int'(busy), 0);
        check({err_timeout, err_overlen} == 2'b00, "reset_errors", int'({err_timeout, err_overlen}), 0);
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;

        // Single 100-nibble frame from source 0 carrying a counting pattern.
        f = mk(100, 0, 0, 1'b1, 1'b0);
        f.base = 0;
        f.step = 1;
        pq0.push_back(f);
        issue();
        drain(t_done);
        check(t_done - last_fall == IFG, "busy_release_after_ifg", t_done - last_fall, IFG);

        // Both sources with queued random frames: strict alternation.
        for (int r = 0; r < 2; r++) begin
            n0 = int'($urandom_range(2, 5));
            n1 = int'($urandom_range(2, 5));
            for (int k = 0; k < n0; k++)
                pq0.push_back(mk((k == 0) ? 40 : int'($urandom_range(1, 60)), int'($urandom_range(0, 12)), 0, 1'b0, 1'b0));
            for (int k = 0; k < n1; k++)
                pq1.push_back(mk((k == 0) ? 40 : int'($urandom_range(1, 60)), int'($urandom_range(0, 12)), 0, 1'b0, 1'b0));
            issue();
            drain(t_done);
        end

        // Source 1 wins but never starts; source 0 then gets the line.
        if (model_last == 1) begin
            pq0.push_back(mk(8, 0, 0, 1'b0, 1'b0));
            issue();
            drain(t_done);
        end
        pq1.push_back(mk(1, 0, 1, 1'b0, 1'b0));
        pq0.push_back(mk(30, int'($urandom_range(0, 12)), 0, 1'b0, 1'b0));
        issue();
        drain(t_done);

        // Over-length frame: 4000 nibbles offered, MAXN forwarded.
        pq0.push_back(mk(4000, 0, 0, 1'b0, 1'b0));
        issue();
        drain(t_done);

        // Reset in the middle of a frame.
        pq0.push_back(mk(60, 0, 0, 1'b0, 1'b1));
        issue();
        cnt = 0;
        for (int t = 0; t < 300 && cnt < 20; t++) begin
            @(posedge clk); #1;
            if (tx_dv) cnt++;
        end
        check(cnt == 20, "reset_frame_started", cnt, 20);
        sys_rst_n    = 1'b0;
        abort_req[0] = 1'b1;
        @(posedge clk); #1;
        check(tx_dv == 1'b0, "midframe_reset_tx_dv", int'(tx_dv), 0);
        check(src_gnt == 2'b00, "midframe_reset_gnt", int'(src_gnt), 0);
        check(busy == 1'b0, "midframe_reset_idle", int'(busy), 0);
        sys_rst_n  = 1'b1;
        model_last = 1;
        drain(t_done);
        pq0.push_back(mk(20, 0, 0, 1'b0, 1'b0));
        pq1.push_back(mk(20, 0, 0, 1'b0, 1'b0));
        issue();
        drain(t_done);

        // Source 1 toggles dv/data without a grant, then drops its request while granted.
        noise[1] = 1'b1;
        pq0.push_back(mk(50, int'($urandom_range(0, 12)), 0, 1'b0, 1'b0));
        issue();
        drain(t_done);
        noise[1] = 1'b0;
        repeat (3) @(posedge clk);
        pq1.push_back(mk(1, 0, 2, 1'b0, 1'b0));
        issue();
        drain(t_done);

        repeat (5) @(posedge clk);
        #1;
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        check(st_q0.size() + st_q1.size() == 0, "start_queue_empty", st_q0.size() + st_q1.size(), 0);
        check(n_tmo == exp_tmo, "timeout_pulse_count", n_tmo, exp_tmo);
        check(n_ovl == exp_ovl, "overlen_pulse_count", n_ovl, exp_ovl);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
